// File: rtl/cpu_execute_mc.sv
// Execute stage with a valid/ready handshake and downstream stall.
// ALU ops finish in one cycle; MULU/DIVU/REMU run on an iterative unit
// that processes one bit per clock.
module cpu_execute_mc #(
  parameter int DW = 32,
  parameter int TW = 3,
  parameter int IW = 48,
  parameter int CW = 6
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              valid_2a,
  output logic              ready_2a,
  input  logic [3:0]        op_2a,
  input  logic [1:0]        c__alu_left_2a,
  input  logic [1:0]        c__alu_right_2a,
  input  logic              c__r0_2a,
  input  logic              c__r1_2a,
  input  logic [1:0]        c__branch_2a,
  input  logic [2:0]        c__to_push_2a,
  input  logic [10:0]       st__to_pop_2a,
  input  logic [IW-1:0]     instruction_2a,
  input  logic [31:0]       pc_2a,
  input  logic [DW+TW-1:0]  st__top_0_2a,
  input  logic [DW+TW-1:0]  st__top_1_2a,
  input  logic              kill_4a,
  input  logic              stall_3a,
  output logic              valid_3a,
  output logic              busy,
  output logic [DW-1:0]     alu__out_3a,
  output logic              alu__cond_3a,
  output logic [1:0]        c__branch_3a,
  output logic [2:0]        c__to_push_3a,
  output logic [10:0]       st__to_pop_3a,
  output logic [IW-1:0]     instruction_3a,
  output logic [31:0]       pc_3a,
  output logic [DW+TW-1:0]  r0_3a,
  output logic [DW+TW-1:0]  r1_3a
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_EQ   = 4'd6;
  localparam logic [3:0] OP_MULU = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;
  localparam logic [3:0] OP_REMU = 4'd9;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic          accept, is_mc, last_iter;
  logic [DW-1:0] left, right, alu_res;
  logic          alu_cond;
  // Iterative unit: opa = multiplicand / dividend-quotient shifter,
  // opb = multiplier / divisor, acc = product / partial remainder.
  logic [CW-1:0] count;
  logic [3:0]    mc_op;
  logic          dz;
  logic [DW-1:0] opa, opb, acc;
  logic [DW-1:0] mul_acc_n, div_rem_n, div_q_n, mc_res;
  logic [DW:0]   div_sh, div_diff;
  logic          mc_cond;

  // Operand selection from immediate or stack entries
  always_comb begin
    left = '0;
    right = '0;
    case (c__alu_left_2a)
      2'd0:    left = instruction_2a[DW-1:0];
      2'd1:    left = st__top_0_2a[DW-1:0];
      2'd2:    left = st__top_1_2a[DW-1:0];
      default: left = '0;
    endcase
    case (c__alu_right_2a)
      2'd0:    right = instruction_2a[DW-1:0];
      2'd1:    right = st__top_0_2a[DW-1:0];
      2'd2:    right = st__top_1_2a[DW-1:0];
      default: right = '0;
    endcase
  end

  // Single-cycle ALU
  always_comb begin
    alu_res = '0;
    alu_cond = 1'b0;
    case (op_2a)
      OP_ADD:  alu_res = left + right;
      OP_SUB:  alu_res = left - right;
      OP_AND:  alu_res = left & right;
      OP_OR:   alu_res = left | right;
      OP_XOR:  alu_res = left ^ right;
      OP_SLTU: alu_cond = (left < right);
      OP_EQ:   alu_cond = (left == right);
      default: alu_res = '0;
    endcase
    if (op_2a <= OP_XOR)
      alu_cond = |alu_res;
    else if (op_2a == OP_SLTU || op_2a == OP_EQ)
      alu_res = {{(DW-1){1'b0}}, alu_cond};
  end

  // One shift-add / restoring-divide step and the final result mux
  always_comb begin
    mul_acc_n = acc + (opb[0] ? opa : '0);
    div_sh    = {acc, opa[DW-1]};
    div_diff  = div_sh - {1'b0, opb};
    div_rem_n = div_diff[DW] ? div_sh[DW-1:0] : div_diff[DW-1:0];
    div_q_n   = {opa[DW-2:0], ~div_diff[DW]};
    case (mc_op)
      OP_MULU: mc_res = mul_acc_n;
      OP_DIVU: mc_res = dz ? '1 : div_q_n;
      default: mc_res = dz ? opa : div_rem_n;
    endcase
    mc_cond = (mc_op != OP_MULU) && dz;
  end

  // Handshake and next-state logic
  always_comb begin
    ready_2a  = (state == IDLE) && !(valid_3a && stall_3a) && !kill_4a;
    accept    = valid_2a && ready_2a;
    is_mc     = (op_2a == OP_MULU) || (op_2a == OP_DIVU) || (op_2a == OP_REMU);
    last_iter = (state == BUSY) && (count == CW'(1));
    busy      = (state == BUSY);
    state_nxt = state;
    if (kill_4a)
      state_nxt = IDLE;
    else if (accept && is_mc)
      state_nxt = BUSY;
    else if (last_iter)
      state_nxt = IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // Output registers and iterative datapath; kill outranks accept/iterate
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_3a       <= 1'b0;
      alu__out_3a    <= '0;
      alu__cond_3a   <= 1'b0;
      c__branch_3a   <= '0;
      c__to_push_3a  <= '0;
      st__to_pop_3a  <= '0;
      instruction_3a <= '0;
      pc_3a          <= '0;
      r0_3a          <= '0;
      r1_3a          <= '0;
      count          <= '0;
      mc_op          <= '0;
      dz             <= 1'b0;
      opa            <= '0;
      opb            <= '0;
      acc            <= '0;
    end else if (kill_4a) begin
      valid_3a      <= 1'b0;
      c__branch_3a  <= '0;
      c__to_push_3a <= '0;
      st__to_pop_3a <= '0;
      count         <= '0;
    end else if (accept) begin
      c__branch_3a   <= c__branch_2a;
      c__to_push_3a  <= c__to_push_2a;
      st__to_pop_3a  <= st__to_pop_2a;
      instruction_3a <= instruction_2a;
      pc_3a          <= pc_2a;
      if (c__r0_2a) r0_3a <= st__top_0_2a;
      if (c__r1_2a) r1_3a <= st__top_1_2a;
      if (is_mc) begin
        valid_3a <= 1'b0;
        count    <= CW'(DW);
        mc_op    <= op_2a;
        dz       <= (right == '0);
        opa      <= left;
        opb      <= right;
        acc      <= '0;
      end else begin
        valid_3a     <= 1'b1;
        alu__out_3a  <= alu_res;
        alu__cond_3a <= alu_cond;
      end
    end else if (state == BUSY) begin
      count <= count - CW'(1);
      if (mc_op == OP_MULU) begin
        acc <= mul_acc_n;
        opa <= opa << 1;
        opb <= opb >> 1;
      end else if (!dz) begin
        // Divide-by-zero keeps the dividend in opa for the REMU result
        acc <= div_rem_n;
        opa <= div_q_n;
      end
      if (last_iter) begin
        alu__out_3a  <= mc_res;
        alu__cond_3a <= mc_cond;
        valid_3a     <= 1'b1;
      end
    end else if (valid_3a && !stall_3a) begin
      valid_3a      <= 1'b0;
      c__branch_3a  <= '0;
      c__to_push_3a <= '0;
      st__to_pop_3a <= '0;
    end
  end

endmodule

// File: tb/tb_cpu_execute_mc.sv
// Self-checking bench for cpu_execute_mc: directed test-plan cases plus
// randomized operations scored against an arithmetic reference model.
module tb_cpu_execute_mc;

  localparam int DW = 32;
  localparam int TW = 3;
  localparam int IW = 48;
  localparam int CW = 6;

  logic              clk, rst_b;
  logic              valid_2a, ready_2a;
  logic [3:0]        op_2a;
  logic [1:0]        c__alu_left_2a, c__alu_right_2a;
  logic              c__r0_2a, c__r1_2a;
  logic [1:0]        c__branch_2a;
  logic [2:0]        c__to_push_2a;
  logic [10:0]       st__to_pop_2a;
  logic [IW-1:0]     instruction_2a;
  logic [31:0]       pc_2a;
  logic [DW+TW-1:0]  st__top_0_2a, st__top_1_2a;
  logic              kill_4a, stall_3a;
  logic              valid_3a, busy;
  logic [DW-1:0]     alu__out_3a;
  logic              alu__cond_3a;
  logic [1:0]        c__branch_3a;
  logic [2:0]        c__to_push_3a;
  logic [10:0]       st__to_pop_3a;
  logic [IW-1:0]     instruction_3a;
  logic [31:0]       pc_3a;
  logic [DW+TW-1:0]  r0_3a, r1_3a;

  cpu_execute_mc #(.DW(DW), .TW(TW), .IW(IW), .CW(CW)) dut (
    .clk(clk), .rst_b(rst_b), .valid_2a(valid_2a), .ready_2a(ready_2a),
    .op_2a(op_2a), .c__alu_left_2a(c__alu_left_2a), .c__alu_right_2a(c__alu_right_2a),
    .c__r0_2a(c__r0_2a), .c__r1_2a(c__r1_2a), .c__branch_2a(c__branch_2a),
    .c__to_push_2a(c__to_push_2a), .st__to_pop_2a(st__to_pop_2a),
    .instruction_2a(instruction_2a), .pc_2a(pc_2a),
    .st__top_0_2a(st__top_0_2a), .st__top_1_2a(st__top_1_2a),
    .kill_4a(kill_4a), .stall_3a(stall_3a), .valid_3a(valid_3a), .busy(busy),
    .alu__out_3a(alu__out_3a), .alu__cond_3a(alu__cond_3a),
    .c__branch_3a(c__branch_3a), .c__to_push_3a(c__to_push_3a),
    .st__to_pop_3a(st__to_pop_3a), .instruction_3a(instruction_3a),
    .pc_3a(pc_3a), .r0_3a(r0_3a), .r1_3a(r1_3a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected visible state
  logic             exp_valid, exp_cond;
  logic [DW-1:0]    exp_out;
  logic [1:0]       exp_branch;
  logic [2:0]       exp_push;
  logic [10:0]      exp_pop;
  logic [IW-1:0]    exp_instr;
  logic [31:0]      exp_pc;
  logic [DW+TW-1:0] exp_r0, exp_r1;

  // Instruction currently offered at 2a
  logic [3:0]       p_op;
  logic [DW-1:0]    p_res;
  logic             p_cond, p_r0c, p_r1c;
  logic [1:0]       p_branch;
  logic [2:0]       p_push;
  logic [10:0]      p_pop;
  logic [IW-1:0]    p_instr;
  logic [31:0]      p_pc;
  logic [DW+TW-1:0] p_t0, p_t1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] opnd(input logic [1:0] code, input logic [IW-1:0] ins,
                                         input logic [DW+TW-1:0] t0, input logic [DW+TW-1:0] t1);
    if (code == 2'd0) return ins[DW-1:0];
    if (code == 2'd1) return t0[DW-1:0];
    if (code == 2'd2) return t1[DW-1:0];
    return '0;
  endfunction

  // Reference result {cond, value} from plain arithmetic
  function automatic logic [DW:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic c;
    r = '0;
    c = 1'b0;
    case (op)
      4'd0: begin r = a + b; c = (r != 0); end
      4'd1: begin r = a - b; c = (r != 0); end
      4'd2: begin r = a & b; c = (r != 0); end
      4'd3: begin r = a | b; c = (r != 0); end
      4'd4: begin r = a ^ b; c = (r != 0); end
      4'd5: begin c = (a < b);  r = DW'(c); end
      4'd6: begin c = (a == b); r = DW'(c); end
      4'd7: r = a * b;
      4'd8: if (b == 0) begin r = '1; c = 1'b1; end else r = a / b;
      4'd9: if (b == 0) begin r = a;  c = 1'b1; end else r = a % b;
      default: ;
    endcase
    return {c, r};
  endfunction

  function automatic bit is_mc(input logic [3:0] op);
    return (op >= 4'd7) && (op <= 4'd9);
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".valid"}, 64'(valid_3a), 64'(exp_valid));
    chk({ph, ".out"},   64'(alu__out_3a), 64'(exp_out));
    chk({ph, ".cond"},  64'(alu__cond_3a), 64'(exp_cond));
    chk({ph, ".branch"}, 64'(c__branch_3a), 64'(exp_branch));
    chk({ph, ".push"},  64'(c__to_push_3a), 64'(exp_push));
    chk({ph, ".pop"},   64'(st__to_pop_3a), 64'(exp_pop));
    chk({ph, ".instr"}, 64'(instruction_3a), 64'(exp_instr));
    chk({ph, ".pc"},    64'(pc_3a), 64'(exp_pc));
    chk({ph, ".r0"},    64'(r0_3a), 64'(exp_r0));
    chk({ph, ".r1"},    64'(r1_3a), 64'(exp_r1));
    chk({ph, ".busy"},  64'(busy), 64'(0));
  endtask

  task automatic clear_exp();
    exp_valid = 0; exp_cond = 0; exp_out = '0; exp_branch = '0; exp_push = '0;
    exp_pop = '0; exp_instr = '0; exp_pc = '0; exp_r0 = '0; exp_r1 = '0;
  endtask

  // Present an instruction at 2a with random sideband
  task automatic drive_inst(input logic [3:0] op, input logic [1:0] ls, input logic [1:0] rs,
                            input logic [DW-1:0] imm, input logic [DW-1:0] v0,
                            input logic [DW-1:0] v1, input logic r0c, input logic r1c);
    logic [DW:0] rr;
    p_op = op; p_r0c = r0c; p_r1c = r1c;
    p_instr = {(IW-DW)'($urandom()), imm};
    p_t0 = {TW'($urandom()), v0};
    p_t1 = {TW'($urandom()), v1};
    p_branch = 2'($urandom_range(0, 3));
    p_push = 3'($urandom_range(0, 7));
    p_pop = 11'($urandom_range(0, 2047));
    p_pc = $urandom();
    rr = ref_alu(op, opnd(ls, p_instr, p_t0, p_t1), opnd(rs, p_instr, p_t0, p_t1));
    p_res = rr[DW-1:0];
    p_cond = rr[DW];
    valid_2a = 1'b1; op_2a = op; c__alu_left_2a = ls; c__alu_right_2a = rs;
    c__r0_2a = r0c; c__r1_2a = r1c; c__branch_2a = p_branch; c__to_push_2a = p_push;
    st__to_pop_2a = p_pop; instruction_2a = p_instr; pc_2a = p_pc;
    st__top_0_2a = p_t0; st__top_1_2a = p_t1;
    #1;
  endtask

  task automatic apply_accept();
    exp_branch = p_branch; exp_push = p_push; exp_pop = p_pop;
    exp_instr = p_instr; exp_pc = p_pc;
    if (p_r0c) exp_r0 = p_t0;
    if (p_r1c) exp_r1 = p_t1;
    if (is_mc(p_op)) exp_valid = 0;
    else begin exp_valid = 1; exp_out = p_res; exp_cond = p_cond; end
  endtask

  // Accept the offered instruction and wait for its result
  task automatic take(input string ph);
    chk({ph, ".ready"}, 64'(ready_2a), 64'(1));
    @(posedge clk); #1;
    valid_2a = 1'b0;
    apply_accept();
    if (is_mc(p_op)) begin
      for (int k = 1; k <= DW; k++) begin
        chk({ph, ".busy_hi"}, 64'(busy), 64'(1));
        chk({ph, ".ready_lo"}, 64'(ready_2a), 64'(0));
        @(posedge clk); #1;
      end
      exp_valid = 1; exp_out = p_res; exp_cond = p_cond;
    end
    check_all(ph);
  endtask

  // One edge with nothing offered
  task automatic idle(input string ph);
    valid_2a = 1'b0;
    @(posedge clk); #1;
    if (exp_valid && !stall_3a) begin
      exp_valid = 0; exp_branch = '0; exp_push = '0; exp_pop = '0;
    end
    check_all(ph);
  endtask

  // Directed test plan followed by randomized operations
  initial begin
    rst_b = 1'b0; valid_2a = 0; op_2a = '0; c__alu_left_2a = '0; c__alu_right_2a = '0;
    c__r0_2a = 0; c__r1_2a = 0; c__branch_2a = '0; c__to_push_2a = '0; st__to_pop_2a = '0;
    instruction_2a = '0; pc_2a = '0; st__top_0_2a = '0; st__top_1_2a = '0;
    kill_4a = 0; stall_3a = 0;
    clear_exp();
    #2;
    check_all("reset");
    chk("reset.ready", 64'(ready_2a), 64'(1));
    kill_4a = 1; #1;
    chk("kill.ready_lo", 64'(ready_2a), 64'(0));
    kill_4a = 0;
    #9 rst_b = 1'b1;
    @(posedge clk); #1;
    check_all("post_reset");

    // ADD imm 5 + stk0 0xFFFFFFFE
    drive_inst(4'd0, 2'd0, 2'd1, 32'h5, 32'hFFFF_FFFE, 32'h0, 1, 0);
    take("add");
    chk("add.value", 64'(alu__out_3a), 64'h3);
    idle("bubble");

    // MULU then back-to-back ADD
    drive_inst(4'd7, 2'd1, 2'd2, 32'h0, 32'h0001_0003, 32'h0000_0010, 0, 1);
    take("mulu");
    chk("mulu.value", 64'(alu__out_3a), 64'h0010_0030);
    drive_inst(4'd0, 2'd0, 2'd3, 32'h1234, 32'h0, 32'h0, 0, 0);
    take("add_b2b");

    drive_inst(4'd8, 2'd0, 2'd1, 32'd100, 32'd7, 32'd0, 0, 0);
    take("divu");
    chk("divu.value", 64'(alu__out_3a), 64'h0E);
    drive_inst(4'd9, 2'd0, 2'd1, 32'd100, 32'd7, 32'd0, 0, 0);
    take("remu");
    chk("remu.value", 64'(alu__out_3a), 64'h02);
    drive_inst(4'd8, 2'd0, 2'd3, 32'd5, 32'd0, 32'd0, 0, 0);
    take("divu0");
    chk("divu0.value", 64'(alu__out_3a), 64'hFFFF_FFFF);
    chk("divu0.cond", 64'(alu__cond_3a), 64'(1));
    drive_inst(4'd9, 2'd0, 2'd3, 32'd5, 32'd0, 32'd0, 0, 0);
    take("remu0");
    chk("remu0.value", 64'(alu__out_3a), 64'h5);

    // Stall holds outputs and blocks acceptance
    drive_inst(4'd0, 2'd0, 2'd1, 32'd9, 32'd1, 32'd0, 1, 1);
    take("add_pre_stall");
    stall_3a = 1'b1;
    drive_inst(4'd1, 2'd0, 2'd1, 32'd1, 32'd2, 32'd0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      chk("stall.ready_lo", 64'(ready_2a), 64'(0));
      @(posedge clk); #1;
      check_all("stall_hold");
    end
    stall_3a = 1'b0; #1;
    take("sub_after_stall");
    chk("sub.value", 64'(alu__out_3a), 64'hFFFF_FFFF);

    // Kill at the tenth busy edge of a DIVU
    drive_inst(4'd8, 2'd1, 2'd2, 32'h0, 32'd1000, 32'd3, 0, 1);
    chk("kill_div.ready", 64'(ready_2a), 64'(1));
    @(posedge clk); #1;
    valid_2a = 1'b0;
    apply_accept();
    repeat (9) @(posedge clk);
    #1;
    chk("kill_div.busy_hi", 64'(busy), 64'(1));
    kill_4a = 1'b1;
    @(posedge clk); #1;
    kill_4a = 1'b0;
    exp_valid = 0; exp_branch = '0; exp_push = '0; exp_pop = '0;
    check_all("killed");
    for (int i = 0; i < DW; i++) idle("after_kill");
    drive_inst(4'd0, 2'd1, 2'd2, 32'h0, 32'd40, 32'd2, 0, 0);
    take("add_after_kill");

    // Asynchronous reset in the middle of a MULU
    drive_inst(4'd7, 2'd1, 2'd2, 32'h0, 32'd12345, 32'd678, 1, 1);
    chk("rst_mul.ready", 64'(ready_2a), 64'(1));
    @(posedge clk); #1;
    valid_2a = 1'b0;
    apply_accept();
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mul.busy_hi", 64'(busy), 64'(1));
    #2 rst_b = 1'b0;
    #1;
    clear_exp();
    check_all("async_reset");
    chk("async_reset.ready", 64'(ready_2a), 64'(1));
    #2 rst_b = 1'b1;
    @(posedge clk); #1;
    check_all("after_release");
    drive_inst(4'd4, 2'd0, 2'd3, 32'hA5A5_0000, 32'h0, 32'h0, 1, 0);
    take("xor_after_reset");

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      logic [3:0] op;
      logic [1:0] ls, rs;
      op = 4'($urandom_range(0, 15));
      if (i % 3 == 0) op = 4'($urandom_range(5, 9));
      ls = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      if ((op == 4'd8 || op == 4'd9) && $urandom_range(0, 3) == 0) rs = 2'd3;
      drive_inst(op, ls, rs, $urandom(), $urandom(), $urandom_range(0, 2) == 0 ? 32'($urandom_range(1, 300)) : $urandom(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      take("rand");
      if ($urandom_range(0, 1) == 1) idle("rand_bubble");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_execute_mc.md
Name: cpu_execute_mc

Overview:
- Parametrised successor of the single-cycle execute stage. Sits between decode/stack-read (2a) and memory/writeback (3a).
- Adds width parameters, a valid/ready handshake with downstream stall, and an iterative multi-cycle unit for MULU/DIVU/REMU alongside the single-cycle ALU ops.
- Kill from 4a squashes both the accepting instruction and any in-flight multi-cycle op.

Parameters:
DW, 32, datapath/ALU width (>=4)
TW, 3, stack-entry tag width; stack entries are DW+TW bits
IW, 48, instruction width (>=DW); immediate = instruction[DW-1:0]
CW, 6, iteration counter width; must satisfy 2^CW > DW

Ports:
clk  in  1  clock
rst_b  in  1  async active-low reset
valid_2a  in  1  instruction present at 2a
ready_2a  out  1  stage can accept (combinational)
op_2a  in  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLTU,6 EQ,7 MULU,8 DIVU,9 REMU, others → result 0, cond 0
c__alu_left_2a  in  2  0 IMM,1 STK0,2 STK1,3 zero
c__alu_right_2a  in  2  same encoding
c__r0_2a  in  1  capture st__top_0 into r0_3a
c__r1_2a  in  1  capture st__top_1 into r1_3a
c__branch_2a  in  2  branch control, passed through
c__to_push_2a  in  3  push count, passed through
st__to_pop_2a  in  11  pop mask, passed through
instruction_2a  in  IW  instruction
pc_2a  in  32  PC
st__top_0_2a  in  DW+TW  stack top
st__top_1_2a  in  DW+TW  stack second
kill_4a  in  1  squash
stall_3a  in  1  downstream cannot take 3a this cycle
valid_3a  out  1  3a outputs valid
busy  out  1  multi-cycle op in flight
alu__out_3a  out  DW  result
alu__cond_3a  out  1  condition
c__branch_3a / c__to_push_3a / st__to_pop_3a  out  2/3/11  registered controls
instruction_3a / pc_3a  out  IW/32  registered sideband
r0_3a / r1_3a  out  DW+TW  captured stack values

Behaviour:
- Reset: every output register 0, state IDLE, counter 0. ready_2a = 1 after reset unless kill_4a is high.
- Operand select: low DW bits of the stack entry for STK0/STK1. Code 3 gives 0.
- ready_2a = (state==IDLE) && !(valid_3a && stall_3a) && !kill_4a.
- accept = valid_2a && ready_2a.
- Single-cycle op (0-6) on accept:
  - At the next edge, load all _3a outputs and set valid_3a=1.
  - Latency is 1.
  - SUB wraps mod 2^DW.
  - SLTU/EQ: alu__out_3a = {DW-1 zeros, cond}; alu__cond_3a = cond.
  - For ADD/SUB/logic ops, alu__cond_3a = (result != 0).
- Multi-cycle op (7-9) on accept:
  - At the accept edge, latch operands and sideband, go to BUSY, set counter=DW, set valid_3a=0.
  - Each BUSY edge performs one iteration: MULU is shift-add; DIVU/REMU is restoring divide, 1 bit per edge.
  - At the DW-th BUSY edge, write the result to alu__out_3a, set valid_3a=1, go to IDLE.
  - valid_3a therefore rises DW edges after the accept edge. busy=1 while in BUSY.
  - MULU returns the low DW bits of the product.
  - Divide by zero: DIVU returns all ones; REMU returns the left operand. alu__cond_3a = 1 on divide by zero, else 0.
- Sideband on accept:
  - instruction_3a, pc_3a, c__branch_3a, c__to_push_3a and st__to_pop_3a are loaded.
  - r0_3a loads only if c__r0_2a, r1_3a only if c__r1_2a; otherwise they hold.
- Stall: while valid_3a && stall_3a, all _3a outputs hold and no accept occurs.
- Output bubble: if valid_3a && !stall_3a and there is no accept, valid_3a drops to 0 next edge. Controls clear to 0; other outputs hold.
- Kill (priority over everything except reset):
  - On a kill_4a edge: valid_3a<=0; c__branch_3a, c__to_push_3a, st__to_pop_3a <= 0; state<=IDLE; counter<=0.
  - r0_3a/r1_3a are not modified.
  - This holds even when stall_3a is high.
- Reset asserted mid-BUSY: immediate return to the reset state; no result is produced.

Test Plan:
- DW=32: ADD with IMM=0x0000_0005 and STK0=0xFFFF_FFFE, no stall → one cycle later valid_3a=1, alu__out_3a=0x0000_0003, alu__cond_3a=1.
- MULU 0x0001_0003 × 0x0000_0010 accepted at edge N → ready_2a=0 and busy=1 for edges N+1..N+32; valid_3a=1 after edge N+32 with alu__out_3a=0x0010_0030. Back-to-back ADD accepted the cycle after completion.
- DIVU 100/7 → 0x0E; REMU 100/7 → 0x02; DIVU 5/0 → 0xFFFF_FFFF with cond=1; REMU 5/0 → 0x5.
- ADD completes, then stall_3a held for 3 cycles while valid_2a stays high with a new op → outputs unchanged and ready_2a=0 for 3 cycles. Stall released → new result the following edge.
- kill_4a pulsed at BUSY edge 10 of a DIVU → busy=0, valid_3a stays 0, st__to_pop_3a=0, r0_3a unchanged. Next ADD accepted normally.
- rst_b dropped asynchronously mid-MULU → all outputs 0 immediately. ready_2a=1 after release.
